// File: rtl/md_iter_unit.sv
//
// md_iter_unit
// ------------
// Iterative multiply/divide engine for the EXE stage. One operation is in
// flight at a time. Multiplies use radix-2 shift-add and divides use
// restoring division. Both retire one bit per clock, so an operation takes
// WIDTH cycles. A divide by zero finishes after a single edge.
//
// Signed operations are computed on operand magnitudes. The sign of the
// result is fixed on the same edge that the last iteration completes.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   start_i   launch an operation (sampled only while idle)
//   op_i      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start_i)
//   a_i       multiplicand / dividend
//   b_i       multiplier / divisor
//   cancel_i  pipeline flush: abort and return to idle
//   hold_i    downstream stall: keep the finished result presented
//   busy_o    operation accepted and not yet retired
//   ready_o   result valid on hi_o/lo_o/dbz_o
//   hi_o      product high half / remainder
//   lo_o      product low half / quotient
//   dbz_o     divide-by-zero flag, valid with ready_o
//
module md_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    input  logic             hold_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    // Multiplicand for multiplies, divisor for divides.
    logic [WIDTH-1:0]   opnd;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dbz_q;

    // Decode of the launch request.
    logic               in_signed;
    logic               in_div;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               div_by_zero;
    logic               launch;
    logic               last_iter;

    // Datapath for one iteration and the final sign fix.
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] mul_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    always_comb begin
        in_signed   = ~op_i[0];
        in_div      = op_i[1];
        abs_a       = (in_signed && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
        abs_b       = (in_signed && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
        div_by_zero = in_div && (b_i == '0);
        launch      = (state == ST_IDLE) && start_i && !cancel_i;
        last_iter   = (state == ST_CALC) && (cnt == LAST_CNT);
    end

    // One iteration of the datapath.
    //  - Multiply: add the multiplicand into the high half when the current
    //    multiplier bit is set, then shift the whole accumulator right. The
    //    carry out of the add becomes the new top bit.
    //  - Divide: shift the next dividend bit into the partial remainder and
    //    trial-subtract the divisor. A clear borrow bit means the subtraction
    //    fits. The quotient bit enters at the bottom as the dividend shifts out.
    //    The partial remainder stays below the divisor, so a successful
    //    difference never needs more than WIDTH bits.
    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        acc_step  = acc;
        if (op_div) begin
            if (!div_diff[WIDTH]) begin
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_step = {add_sum, acc[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    // Sign correction for the final iteration. Most-negative / -1 works out
    // without a special case: the quotient magnitude 2^(WIDTH-1) is left
    // un-negated because both operands are negative, so it reads back as the
    // most negative value with a zero remainder.
    always_comb begin
        mul_fixed = neg_q ? (~acc_step + 1'b1) : acc_step;
        quo_fixed = neg_q ? (~acc_step[WIDTH-1:0] + 1'b1)
                          : acc_step[WIDTH-1:0];
        rem_fixed = neg_r ? (~acc_step[2*WIDTH-1:WIDTH] + 1'b1)
                          : acc_step[2*WIDTH-1:WIDTH];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state. A flush overrides every other request.
    always_comb begin
        state_nxt = state;
        if (cancel_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state_nxt = div_by_zero ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (last_iter) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!hold_i) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Operand capture, iteration and the result registers. The results are
    // written only on entry to DONE. A flush leaves them as they were.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dbz_q  <= 1'b0;
        end else if (cancel_i) begin
            cnt <= '0;
        end else if (launch) begin
            cnt    <= '0;
            op_div <= in_div;
            neg_q  <= in_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r  <= in_signed & a_i[WIDTH-1];
            opnd   <= in_div ? abs_b : abs_a;
            acc    <= {{WIDTH{1'b0}}, (in_div ? abs_a : abs_b)};
            if (div_by_zero) begin
                hi_q  <= a_i;
                lo_q  <= '1;
                dbz_q <= 1'b1;
            end
        end else if (state == ST_CALC) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
                dbz_q <= 1'b0;
                if (op_div) begin
                    hi_q <= rem_fixed;
                    lo_q <= quo_fixed;
                end else begin
                    hi_q <= mul_fixed[2*WIDTH-1:WIDTH];
                    lo_q <= mul_fixed[WIDTH-1:0];
                end
            end
        end
    end

    assign busy_o  = (state != ST_IDLE);
    assign ready_o = (state == ST_DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign dbz_o   = dbz_q;

endmodule

// File: tb/tb_md_iter_unit.sv
//
// tb_md_iter_unit
// ---------------
// Drives a 32-bit and an 8-bit md_iter_unit. Results are checked against an
// arithmetic reference model that uses the simulator's own multiply, divide
// and modulo operators. Directed cases cover the flush, the stall, the
// divide-by-zero path and an asynchronous reset.
//
module tb_md_iter_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        start32 = 1'b0;
    logic [1:0]  op32 = 2'b00;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        cancel32 = 1'b0;
    logic        hold32 = 1'b0;
    logic        busy32;
    logic        ready32;
    logic        dbz32;
    logic [31:0] hi32;
    logic [31:0] lo32;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cancel8 = 1'b0;
    logic        hold8 = 1'b0;
    logic        busy8;
    logic        ready8;
    logic        dbz8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int vectors = 0;
    int miscompares = 0;

    md_iter_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .op_i(op32), .a_i(a32), .b_i(b32),
        .cancel_i(cancel32), .hold_i(hold32), .busy_o(busy32), .ready_o(ready32),
        .hi_o(hi32), .lo_o(lo32), .dbz_o(dbz32)
    );

    md_iter_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
        .cancel_i(cancel8), .hold_i(hold8), .busy_o(busy8), .ready_o(ready8),
        .hi_o(hi8), .lo_o(lo8), .dbz_o(dbz8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sext(input longint unsigned v, input int w);
        longint t;
        t = signed'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    // Reference: plain signed/unsigned arithmetic on w-bit values.
    task automatic refModel(input int w, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] hi,
                            output logic [31:0] lo, output logic dbz);
        longint unsigned mask, ua, ub, p;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = sext(ua, w);
        sb   = sext(ub, w);
        dbz  = 1'b0;
        p    = 64'd0;
        if (op == 2'b00) p = sa * sb;
        if (op == 2'b01) p = ua * ub;
        if (!op[1]) begin
            hi = 32'((p >> w) & mask);
            lo = 32'(p & mask);
        end else if (ub == 64'd0) begin
            hi  = 32'(ua);
            lo  = 32'(mask);
            dbz = 1'b1;
        end else if (op == 2'b10) begin
            hi = 32'(longint'(sa % sb) & longint'(mask));
            lo = 32'(longint'(sa / sb) & longint'(mask));
        end else begin
            hi = 32'(ua % ub);
            lo = 32'(ua / ub);
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy32;
    endfunction
    function automatic logic get_ready(input int w);
        return (w == 8) ? ready8 : ready32;
    endfunction
    function automatic logic get_dbz(input int w);
        return (w == 8) ? dbz8 : dbz32;
    endfunction
    function automatic logic [31:0] get_hi(input int w);
        return (w == 8) ? {24'd0, hi8} : hi32;
    endfunction
    function automatic logic [31:0] get_lo(input int w);
        return (w == 8) ? {24'd0, lo8} : lo32;
    endfunction

    task automatic drive(input int w, input logic s, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = s; op32 = op; a32 = a; b32 = b;
        end
    endtask

    // Launch one operation (hold low), wait for ready with a cycle budget,
    // check latency and results, then check the unit returns to idle.
    task automatic applyStimulus(input int w, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input string tag);
        logic [31:0] ehi, elo;
        logic        edbz;
        int          cycles;
        refModel(w, op, a, b, ehi, elo, edbz);
        @(negedge clk);
        drive(w, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, op, a, b);
        checkOutput({tag, ".busy"}, 64'(get_busy(w)), 64'd1);
        cycles = 0;
        while (!get_ready(w) && cycles < 2 * w + 8) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, ".lat"}, 64'(cycles), edbz ? 64'd0 : 64'(w));
        checkOutput({tag, ".hi"}, 64'(get_hi(w)), 64'(ehi));
        checkOutput({tag, ".lo"}, 64'(get_lo(w)), 64'(elo));
        checkOutput({tag, ".dbz"}, 64'(get_dbz(w)), 64'(edbz));
        @(posedge clk);
        #1;
        checkOutput({tag, ".idle"}, {62'd0, get_busy(w), get_ready(w)}, 64'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] held_hi, held_lo;
        logic        seen;
        int          cycles;

        #1 rst = 1'b0;
        #1;
        checkOutput("reset.busy", 64'(busy32), 64'd0);
        checkOutput("reset.ready", 64'(ready32), 64'd0);
        checkOutput("reset.hilo", {hi32, lo32}, 64'd0);
        checkOutput("reset.dbz", 64'(dbz32), 64'd0);
        checkOutput("reset8.hilo", {48'd0, hi8, lo8}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases with hand-derived results.
        applyStimulus(32, 2'b00, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
        checkOutput("mult_m3x5.k", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFF1);
        applyStimulus(32, 2'b11, 32'd100, 32'd7, "divu_100_7");
        checkOutput("divu_100_7.k", {hi32, lo32}, 64'h0000_0002_0000_000E);
        applyStimulus(32, 2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        checkOutput("div_m7_2.k", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        checkOutput("div_ovf.k", {hi32, lo32}, 64'h0000_0000_8000_0000);
        applyStimulus(32, 2'b10, 32'h1234_5678, 32'd0, "div_zero");
        checkOutput("div_zero.k", {hi32, lo32}, 64'h1234_5678_FFFF_FFFF);
        applyStimulus(8, 2'b00, 32'h7F, 32'h80, "w8_mult");
        checkOutput("w8_mult.k", {48'd0, hi8, lo8}, 64'hC080);

        // Flush after ten iterations: back to idle, no result presented.
        @(negedge clk);
        drive(32, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        drive(32, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        @(negedge clk);
        cancel32 = 1'b1;
        start32  = 1'b1;
        @(posedge clk);
        #1;
        cancel32 = 1'b0;
        start32  = 1'b0;
        checkOutput("cancel.state", {62'd0, busy32, ready32}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready32 || busy32) seen = 1'b1;
        end
        checkOutput("cancel.quiet", 64'(seen), 64'd0);

        // Restart with a stall: result must stay presented and ignore starts.
        @(negedge clk);
        hold32 = 1'b1;
        drive(32, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        drive(32, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cycles = 0;
        while (!ready32 && cycles < 80) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("hold.lat", 64'(cycles), 64'd32);
        checkOutput("hold.result", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
        held_hi = hi32;
        held_lo = lo32;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(32, 1'b1, 2'b10, $urandom, 32'd0);
            @(posedge clk);
            #1;
            drive(32, 1'b0, 2'b00, 32'd0, 32'd0);
            checkOutput("hold.ready", 64'(ready32), 64'd1);
            checkOutput("hold.stable", {hi32, lo32}, {held_hi, held_lo});
            checkOutput("hold.dbz", 64'(dbz32), 64'd0);
        end
        @(negedge clk);
        hold32 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold.release", {62'd0, busy32, ready32}, 64'd0);

        // Randomised operations on both widths.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(32, 2'($urandom_range(0, 3)), pickOperand(), pickOperand(), "rand32");
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8, 2'($urandom_range(0, 3)), pickOperand(), pickOperand(), "rand8");
        end

        // Asynchronous reset in the middle of a calculation.
        applyStimulus(32, 2'b01, 32'h0001_0003, 32'h0002_0005, "pre_reset");
        @(negedge clk);
        drive(32, 1'b1, 2'b11, 32'd1000, 32'd3);
        @(posedge clk);
        #1;
        drive(32, 1'b0, 2'b11, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("areset.state", {62'd0, busy32, ready32}, 64'd0);
        checkOutput("areset.hilo", {hi32, lo32}, 64'd0);
        checkOutput("areset.dbz", 64'(dbz32), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(32, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
